// File: rtl/pipe_skid_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage_pkg
//   Shared definitions for the elastic inter-stage pipeline registers of the
//   MIPS core: handshake FSM state encoding, packed payload bundles per stage
//   boundary, their widths and their bubble (NOP) images.
// -----------------------------------------------------------------------------
package pipe_skid_stage_pkg;

  // Handshake FSM states. The encoding equals the number of held entries,
  // so occupancy falls straight out of the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Fields used to build the bubble images.
  localparam logic [4:0] NOP_REG_ADDR  = 5'd0;
  localparam logic       WRITE_DISABLE = 1'b0;
  localparam logic [7:0] EXE_NOP_OP    = 8'b0000_0000;

  // IF/ID boundary payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  // EX/MEM boundary payload.
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] excepttype;
  } ex_mem_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);

  // Bubble images: write to r0 with writes disabled and a NOP ALU op, so a
  // downstream stage consuming the payload without checking valid is harmless.
  localparam if_id_t IF_ID_NOP = '0;
  localparam ex_mem_t EX_MEM_NOP = '{
    wd:      NOP_REG_ADDR,
    wreg:    WRITE_DISABLE,
    aluop:   EXE_NOP_OP,
    default: '0
  };

  // Number of entries held in a given FSM state.
  function automatic logic [1:0] state_occupancy(input state_t s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_side.sv
// -----------------------------------------------------------------------------
// pipe_side_reg
//   Side-state register carrying a multi-cycle operation's partial result
//   (HI/LO accumulator + cycle count) across stall cycles.
//
//   clk, rst     : clock, synchronous active-high reset
//   flush        : exception flush, clears the state
//   hold         : execute unit is mid-operation, capture load_value
//   up_xfer      : an upstream transfer happens this cycle
//   load_value   : state presented by the execute unit
//   value        : registered state fed back to the execute unit
// -----------------------------------------------------------------------------
module pipe_side_reg
  import pipe_skid_stage_pkg::*;
#(
  parameter int SIDE_W = 66
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              up_xfer,
  input  logic [SIDE_W-1:0] load_value,
  output logic [SIDE_W-1:0] value
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // Aborting mid-operation: the execute unit restarts from count 0.
      value <= '0;
    end else if (hold) begin
      value <= load_value;
    end else if (up_xfer) begin
      // A new instruction enters the stage: stale state must not leak into it.
      value <= '0;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//   Elastic valid/ready pipeline register for one inter-stage boundary.
//   SKID_EN=1: main + skid register, up_ready comes from a flop.
//   SKID_EN=0: single entry, up_ready = dn_ready | ~dn_valid (combinational).
//
//   clk, rst            : clock, synchronous active-high reset
//   flush               : exception flush, discards all held entries
//   up_valid/up_data    : upstream payload, up_ready accepts it
//   dn_valid/dn_data    : downstream payload (NOP_VALUE when not valid)
//   dn_ready            : downstream accepts this cycle
//   side_i/side_hold    : multi-cycle state from the execute unit + keep request
//   side_o              : side state fed back to the execute unit
//   occupancy           : held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                DATA_W    = 160,
  parameter int                SIDE_W    = 66,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter bit                SKID_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_ready,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              dn_ready,
  input  logic [SIDE_W-1:0] side_i,
  input  logic              side_hold,
  output logic [SIDE_W-1:0] side_o,
  output logic [1:0]        occupancy
);

  state_t            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              dn_valid_q;
  logic              up_ready_q;
  logic              up_xfer;
  logic              dn_xfer;

  assign up_xfer = up_valid & up_ready;
  assign dn_xfer = dn_valid_q & dn_ready;

  // The ready flop is preloaded to 1 during reset and masked by rst, so the
  // stage reads not-ready while in reset and ready on the first cycle after.
  assign up_ready  = ~rst & (SKID_EN ? up_ready_q : (dn_ready | ~dn_valid_q));
  assign dn_valid  = dn_valid_q;
  assign dn_data   = main_q;
  assign occupancy = state_occupancy(state_q);

  // Reset and flush produce identical register images; keeping them in one
  // branch guarantees neither falls through into the handshake logic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // NOTE: the payload registers are reset (not just the valid bit) because
      // downstream may consume dn_data without looking at dn_valid.
      state_q    <= ST_EMPTY;
      main_q     <= NOP_VALUE;
      skid_q     <= NOP_VALUE;
      dn_valid_q <= 1'b0;
      up_ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            main_q     <= up_data;
            dn_valid_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (up_xfer && dn_xfer) begin
            main_q <= up_data;
          end else if (dn_xfer) begin
            main_q     <= NOP_VALUE;
            dn_valid_q <= 1'b0;
            state_q    <= ST_EMPTY;
          end else if (up_xfer && SKID_EN) begin
            // Downstream stalled while upstream still had the registered
            // ready: park the new item in the skid slot.
            skid_q     <= up_data;
            up_ready_q <= 1'b0;
            state_q    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (dn_xfer) begin
            main_q     <= skid_q;
            skid_q     <= NOP_VALUE;
            up_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q    <= ST_EMPTY;
          main_q     <= NOP_VALUE;
          skid_q     <= NOP_VALUE;
          dn_valid_q <= 1'b0;
          up_ready_q <= 1'b1;
        end
      endcase
    end
  end

  pipe_side_reg #(
    .SIDE_W (SIDE_W)
  ) u_side (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .hold       (side_hold),
    .up_xfer    (up_xfer),
    .load_value (side_i),
    .value      (side_o)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int             DW  = 32;
  localparam int             SW  = 66;
  localparam logic [DW-1:0]  NOP = 32'h0BAD_F00D;
  localparam int             VW  = 1 + 1 + 2 + DW + SW;
  localparam logic [SW-1:0]  SV  = {64'h0000_0001_FFFF_FFFF, 2'd2};

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          flush     = 1'b0;
  logic          up_valid  = 1'b0;
  logic          dn_ready  = 1'b0;
  logic          side_hold = 1'b0;
  logic [DW-1:0] up_data   = '0;
  logic [SW-1:0] side_i    = '0;

  logic          up_ready_s, dn_valid_s, up_ready_n, dn_valid_n;
  logic [DW-1:0] dn_data_s, dn_data_n;
  logic [SW-1:0] side_o_s, side_o_n;
  logic [1:0]    occ_s, occ_n;

  int checks   = 0;
  int failures = 0;

  // Reference model: each stage is a bounded FIFO of in-flight items.
  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_n[$];
  logic [SW-1:0] side_s = '0;
  logic [SW-1:0] side_n = '0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .SIDE_W(SW), .NOP_VALUE(NOP), .SKID_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready_s),
    .dn_valid(dn_valid_s), .dn_data(dn_data_s), .dn_ready(dn_ready),
    .side_i(side_i), .side_hold(side_hold), .side_o(side_o_s), .occupancy(occ_s)
  );

  pipe_skid_stage #(.DATA_W(DW), .SIDE_W(SW), .NOP_VALUE(NOP), .SKID_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready_n),
    .dn_valid(dn_valid_n), .dn_data(dn_data_n), .dn_ready(dn_ready),
    .side_i(side_i), .side_hold(side_hold), .side_o(side_o_n), .occupancy(occ_n)
  );

  wire [VW-1:0] obs_s = {up_ready_s, dn_valid_s, occ_s, dn_data_s, side_o_s};
  wire [VW-1:0] obs_n = {up_ready_n, dn_valid_n, occ_n, dn_data_n, side_o_n};

  function automatic logic [VW-1:0] exp_s();
    logic          rdy;
    logic [DW-1:0] d;
    rdy = !rst && (q_s.size() < 2);
    d   = (q_s.size() > 0) ? q_s[0] : NOP;
    return {rdy, q_s.size() > 0, 2'(q_s.size()), d, side_s};
  endfunction

  function automatic logic [VW-1:0] exp_n();
    logic          rdy;
    logic [DW-1:0] d;
    rdy = !rst && (q_n.size() == 0 || dn_ready);
    d   = (q_n.size() > 0) ? q_n[0] : NOP;
    return {rdy, q_n.size() > 0, 2'(q_n.size()), d, side_n};
  endfunction

  // Apply inputs away from the active edge.
  task automatic drive(input logic rs, input logic fl, input logic uv, input logic [DW-1:0] ud,
                       input logic dr, input logic sh, input logic [SW-1:0] si);
    @(negedge clk);
    rst = rs; flush = fl; up_valid = uv; up_data = ud;
    dn_ready = dr; side_hold = sh; side_i = si;
    #1;
  endtask

  // Advance one clock edge and update the model with the inputs seen there.
  task automatic tick();
    logic ux_s, dx_s, ux_n, dx_n;
    @(posedge clk);
    if (rst || flush) begin
      q_s.delete(); q_n.delete();
      side_s = '0; side_n = '0;
    end else begin
      ux_s = up_valid && (q_s.size() < 2);
      dx_s = (q_s.size() > 0) && dn_ready;
      ux_n = up_valid && (q_n.size() == 0 || dn_ready);
      dx_n = (q_n.size() > 0) && dn_ready;
      if (side_hold) begin
        side_s = side_i; side_n = side_i;
      end else begin
        if (ux_s) side_s = '0;
        if (ux_n) side_n = '0;
      end
      if (dx_s) void'(q_s.pop_front());
      if (ux_s) q_s.push_back(up_data);
      if (dx_n) void'(q_n.pop_front());
      if (ux_n) q_n.push_back(up_data);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h55, 1'b1, 1'b1, SV);
    checks++;
    if ({up_ready_s, dn_valid_s, occ_s} !== 4'b0000 || dn_data_s !== NOP || side_o_s !== '0) begin
      failures++;
      $display("FAIL reset_skid: got rdy=%b v=%b occ=%0d d=%h side=%h, want 0 0 0 %h 0",
               up_ready_s, dn_valid_s, occ_s, dn_data_s, side_o_s, NOP);
    end
    checks++;
    if (obs_n !== exp_n()) begin
      failures++;
      $display("FAIL reset_noskid: got %h want %h", obs_n, exp_n());
    end
    tick();
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'(i), 1'b1, 1'b0, '0);
      checks++;
      if (i == 1) begin
        if (up_ready_s !== 1'b1 || occ_s !== 2'd0 || dn_data_s !== NOP) begin
          failures++;
          $display("FAIL stream_first: got rdy=%b occ=%0d d=%h, want 1 0 %h", up_ready_s, occ_s, dn_data_s, NOP);
        end
      end else if (dn_data_s !== 32'(i - 1) || dn_valid_s !== 1'b1 || occ_s !== 2'd1 || up_ready_s !== 1'b1) begin
        failures++;
        $display("FAIL stream_item%0d: got d=%h v=%b occ=%0d rdy=%b, want %h 1 1 1",
                 i, dn_data_s, dn_valid_s, occ_s, up_ready_s, i - 1);
      end
      checks++;
      if (obs_n !== exp_n()) begin
        failures++;
        $display("FAIL stream_noskid%0d: got %h want %h", i, obs_n, exp_n());
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checks++;
    if (dn_data_s !== 32'd4 || dn_valid_s !== 1'b1) begin
      failures++;
      $display("FAIL stream_last: got d=%h v=%b, want 4 1", dn_data_s, dn_valid_s);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checks++;
    if (dn_valid_s !== 1'b0 || dn_data_s !== NOP || occ_s !== 2'd0) begin
      failures++;
      $display("FAIL stream_drained: got v=%b d=%h occ=%0d, want 0 %h 0", dn_valid_s, dn_data_s, occ_s, NOP);
    end
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'hB, 1'b0, 1'b0, '0);
    checks++;
    if (occ_s !== 2'd1 || up_ready_s !== 1'b1 || dn_data_s !== 32'hA) begin
      failures++;
      $display("FAIL bp_one: got occ=%0d rdy=%b d=%h, want 1 1 a", occ_s, up_ready_s, dn_data_s);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    checks++;
    if (occ_s !== 2'd2 || up_ready_s !== 1'b0 || dn_data_s !== 32'hA) begin
      failures++;
      $display("FAIL bp_full: got occ=%0d rdy=%b d=%h, want 2 0 a", occ_s, up_ready_s, dn_data_s);
    end
    tick();
    // An offer while FULL must be refused.
    drive(1'b0, 1'b0, 1'b1, 32'hEE, 1'b1, 1'b0, '0);
    checks++;
    if (obs_s !== exp_s() || dn_data_s !== 32'hA) begin
      failures++;
      $display("FAIL bp_drain_a: got %h want %h", obs_s, exp_s());
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checks++;
    if (dn_data_s !== 32'hB || occ_s !== 2'd1 || up_ready_s !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain_b: got d=%h occ=%0d rdy=%b, want b 1 1", dn_data_s, occ_s, up_ready_s);
    end
    checks++;
    if (obs_n !== exp_n()) begin
      failures++;
      $display("FAIL bp_noskid: got %h want %h", obs_n, exp_n());
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checks++;
    if (obs_s !== exp_s() || occ_s !== 2'd0) begin
      failures++;
      $display("FAIL bp_empty: got %h want %h", obs_s, exp_s());
    end
    tick();
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b0, 1'b1, 32'h1A, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h1B, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'hC, 1'b0, 1'b0, '0);
    checks++;
    if (occ_s !== 2'd2) begin
      failures++;
      $display("FAIL flush_pre: got occ=%0d want 2", occ_s);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checks++;
    if ({up_ready_s, dn_valid_s, occ_s} !== 4'b1000 || dn_data_s !== NOP) begin
      failures++;
      $display("FAIL flush_post: got rdy=%b v=%b occ=%0d d=%h, want 1 0 0 %h",
               up_ready_s, dn_valid_s, occ_s, dn_data_s, NOP);
    end
    checks++;
    if (obs_n !== exp_n()) begin
      failures++;
      $display("FAIL flush_noskid: got %h want %h", obs_n, exp_n());
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'hD, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checks++;
    if (dn_data_s !== 32'hD || dn_valid_s !== 1'b1 || occ_s !== 2'd1) begin
      failures++;
      $display("FAIL flush_next: got d=%h v=%b occ=%0d, want d 1 1", dn_data_s, dn_valid_s, occ_s);
    end
    tick();
  endtask

  task automatic test_side();
    drive(1'b0, 1'b0, 1'b1, 32'h2A, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h2B, 1'b0, 1'b0, '0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h2C, 1'b0, 1'b1, SV);
      checks++;
      if (obs_s !== exp_s() || (k > 0 && side_o_s !== SV)) begin
        failures++;
        $display("FAIL side_hold%0d: got %h want %h", k, obs_s, exp_s());
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checks++;
    if (side_o_s !== SV || occ_s !== 2'd2) begin
      failures++;
      $display("FAIL side_kept: got side=%h occ=%0d, want %h 2", side_o_s, occ_s, SV);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h2E, 1'b1, 1'b0, '0);
    checks++;
    if (up_ready_s !== 1'b1 || side_o_s !== SV) begin
      failures++;
      $display("FAIL side_pre_xfer: got rdy=%b side=%h, want 1 %h", up_ready_s, side_o_s, SV);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checks++;
    if (side_o_s !== '0 || dn_data_s !== 32'h2E) begin
      failures++;
      $display("FAIL side_cleared: got side=%h d=%h, want 0 2e", side_o_s, dn_data_s);
    end
    checks++;
    if (obs_n !== exp_n()) begin
      failures++;
      $display("FAIL side_noskid: got %h want %h", obs_n, exp_n());
    end
    tick();
  endtask

  task automatic test_rst_flush();
    drive(1'b0, 1'b0, 1'b1, 32'h3A, 1'b0, 1'b1, SV);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h3B, 1'b0, 1'b1, SV);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h3B, 1'b0, 1'b1, SV);
    checks++;
    if ({up_ready_s, dn_valid_s, occ_s} !== 4'b0000 || dn_data_s !== NOP || side_o_s !== '0) begin
      failures++;
      $display("FAIL rstflush_reset: got %h want %h", obs_s, exp_s());
    end
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'hF, 1'b1, 1'b0, '0);
    checks++;
    if (up_ready_s !== 1'b1 || occ_s !== 2'd0) begin
      failures++;
      $display("FAIL rstflush_release: got rdy=%b occ=%0d, want 1 0", up_ready_s, occ_s);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h36, 1'b1, 1'b0, '0);
    checks++;
    if ({up_ready_s, dn_valid_s, occ_s} !== 4'b1000 || dn_data_s !== NOP || side_o_s !== '0) begin
      failures++;
      $display("FAIL rstflush_flushvals: got %h want %h", obs_s, exp_s());
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checks++;
    if (dn_data_s !== 32'h36 || dn_valid_s !== 1'b1) begin
      failures++;
      $display("FAIL rstflush_resume: got d=%h v=%b, want 36 1", dn_data_s, dn_valid_s);
    end
    tick();
  endtask

  task automatic test_noskid();
    drive(1'b0, 1'b0, 1'b1, 32'h4A, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h4B, 1'b0, 1'b0, '0);
    checks++;
    if (up_ready_n !== 1'b0 || occ_n !== 2'd1 || dn_data_n !== 32'h4A) begin
      failures++;
      $display("FAIL noskid_stall: got rdy=%b occ=%0d d=%h, want 0 1 4a", up_ready_n, occ_n, dn_data_n);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h4B + 32'(i), 1'b1, 1'b0, '0);
      checks++;
      if (up_ready_n !== 1'b1 || dn_data_n !== ((i == 0) ? 32'h4A : 32'h4A + 32'(i)) || dn_valid_n !== 1'b1) begin
        failures++;
        $display("FAIL noskid_stream%0d: got rdy=%b d=%h v=%b", i, up_ready_n, dn_data_n, dn_valid_n);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    tick();
  endtask

  task automatic test_random();
    logic          rs, fl, uv, dr, sh;
    logic [DW-1:0] ud;
    logic [SW-1:0] si;
    for (int i = 0; i < 500; i++) begin
      rs = ($urandom_range(0, 59) == 0);
      fl = ($urandom_range(0, 19) == 0);
      uv = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 9) < 6);
      sh = ($urandom_range(0, 2) == 0);
      ud = $urandom;
      si = {$urandom, $urandom, 2'($urandom_range(0, 3))};
      drive(rs, fl, uv, ud, dr, sh, si);
      checks++;
      if (obs_s !== exp_s()) begin
        failures++;
        $display("FAIL rand_skid cycle %0d: got %h want %h", i, obs_s, exp_s());
      end
      checks++;
      if (obs_n !== exp_n()) begin
        failures++;
        $display("FAIL rand_noskid cycle %0d: got %h want %h", i, obs_n, exp_n());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_side();
    test_rst_flush();
    test_noskid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline register for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) of the MIPS core.
- Replaces the per-stage `stall[5:0]` vector with a valid/ready handshake.
- Holds two entries: a main register plus a skid register, so `up_ready` is fully registered.
- Supports flush on exception and a side-state channel that carries multi-cycle operation state (HI/LO partial result, cycle counter) across stall cycles.

Parameters:
- DATA_W, 160: width of the payload bundle (wd, wreg, wdata, hi, lo, aluop, addr, cp0, excepttype, ...), packed by the instantiating stage.
- SIDE_W, 66: width of the multi-cycle side-state bundle (64-bit HI/LO accumulator + 2-bit count).
- NOP_VALUE, {DATA_W{1'b0}}: payload driven downstream when no valid entry exists (bubble / flush image).
- SKID_EN, 1: 1 gives 2-entry skid mode; 0 gives single-entry mode where `up_ready = dn_ready | ~dn_valid`, which is combinational.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- flush, in, 1: exception flush; discards all held entries.
- up_valid, in, 1: upstream presents a payload.
- up_data, in, DATA_W: upstream payload.
- up_ready, out, 1: stage can accept this cycle.
- dn_valid, out, 1: downstream payload valid.
- dn_data, out, DATA_W: downstream payload.
- dn_ready, in, 1: downstream accepts this cycle.
- side_i, in, SIDE_W: multi-cycle state from the upstream execute unit.
- side_hold, in, 1: upstream is mid multi-cycle op and wants its state preserved.
- side_o, out, SIDE_W: side state fed back to the execute unit.
- occupancy, out, 2: number of held entries (0..2).

Behaviour:
- Priority: rst > flush > handshake. Every branch is mutually exclusive; there is no fall-through from flush into handshake logic.
- Reset values:
  - dn_valid=0, dn_data=NOP_VALUE, side_o=0, occupancy=0.
  - up_ready=1 on the first cycle after reset is released. During reset it is 0.
- Flush values (same cycle's inputs ignored): dn_valid=0, dn_data=NOP_VALUE, skid cleared, side_o=0, occupancy=0, up_ready=1.
- Transfers: an upstream transfer occurs when `up_valid & up_ready`; a downstream transfer occurs when `dn_valid & dn_ready`. Both are sampled at the clock edge.
- States (SKID_EN=1): EMPTY, ONE (main valid), FULL (main + skid valid).
  - EMPTY + up xfer -> ONE. Main <= up_data. Latency 1 cycle from up_data to dn_data.
  - ONE + up xfer + dn xfer -> ONE. Main <= up_data (streaming, 1 item/cycle).
  - ONE + dn xfer only -> EMPTY. dn_data <= NOP_VALUE.
  - ONE + up xfer, no dn xfer -> FULL. Skid <= up_data; up_ready deasserts next cycle.
  - FULL + dn xfer -> ONE. Main <= skid. up_ready=0 in FULL, so no up xfer occurs.
  - No transfers -> hold all.
- up_ready is a register, equal to (next state != FULL).
- Ordering is strictly FIFO; no payload is duplicated or dropped except by flush or rst.
- Whenever dn_valid=0, dn_data must equal NOP_VALUE. Downstream may consume the payload without checking valid.
- Side channel, evaluated in the non-rst, non-flush branch:
  - side_hold=1: side_o <= side_i, independent of the handshake.
  - side_hold=0 and up xfer: side_o <= 0.
  - Otherwise side_o holds its value.
- Reset or flush mid multi-cycle op zeroes side_o. The execute unit restarts from count 0.
- SKID_EN=0: states are EMPTY and ONE only. The FULL transition is illegal; up_ready is combinational.
- No arithmetic on the payload. Widths pass through unchanged.

Decomposition:
- Shared package/defines:
  - FSM state encodings: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Packed bundle width constants per boundary, e.g. EX_MEM_W and IF_ID_W.
  - The NOP payload images, built from the NOP register address, WriteDisable and the NOP aluop.
- Natural sub-module: pipe_side_reg, which holds the side-state register and its hold/clear rules. The main module contains the handshake FSM and the main/skid registers.

Test Plan:
- Reset, then stream: up_valid=1 with data 1,2,3,4 on consecutive cycles, dn_ready=1 -> dn_data shows 1,2,3,4 one cycle later each, dn_valid stays 1, occupancy=1, up_ready stays 1.
- Backpressure: load A, then drop dn_ready to 0 while B arrives -> occupancy=2 and up_ready=0. Raise dn_ready -> A, then B, delivered in order with no loss or duplicate.
- Flush in FULL with up_valid=1 and data C the same cycle -> next cycle dn_valid=0, dn_data=NOP_VALUE, occupancy=0, up_ready=1, and C is never delivered.
- Side state: side_hold=1 with side_i=0x0000_0001_FFFF_FFFF_2 for 3 cycles while stalled -> side_o tracks side_i. Drop side_hold and complete an up xfer -> side_o=0.
- Simultaneous flush and rst -> reset values. Release rst while flush=1 -> flush values, then normal operation on the next up xfer.
- SKID_EN=0 build: dn_ready=0 with occupancy 1 -> up_ready=0 in the same cycle. dn_ready=1 -> up_ready=1 combinationally, with throughput of 1 item/cycle.
